// File: rtl/cellram_pin_mux_if.sv
// Sync-side bundle between cellram_control_sync and cellram_pin_mux.
// The controller (master) drives the pre-muxed pin requests and receives
// the gated WAIT; the pin mux (slave) consumes the requests and returns WAIT.
interface cellram_pin_mux_if;
    logic [22:0] sync_addr;
    logic        sync_adv_n;
    logic        sync_cre;
    logic        sync_ce_n;
    logic        sync_oe_n;
    logic        sync_we_n;
    logic        sync_lb_n;
    logic        sync_ub_n;
    logic        sync_wait;

    modport master (
        output sync_addr, sync_adv_n, sync_cre, sync_ce_n,
               sync_oe_n, sync_we_n, sync_lb_n, sync_ub_n,
        input  sync_wait
    );

    modport slave (
        input  sync_addr, sync_adv_n, sync_cre, sync_ce_n,
               sync_oe_n, sync_we_n, sync_lb_n, sync_ub_n,
        output sync_wait
    );
endinterface

// File: rtl/cellram_pin_mux.sv
// CellularRAM pin stage: after reset it waits out device power-up, writes
// the BCR with an asynchronous CRE write, then hands the pins to the
// synchronous controller. A cfg_req while the sync side is idle re-runs
// the configuration write (without repeating power-up).
// Optional macro CELLRAM_RCR_WRITE_EN: adds a second configuration pass
// writing CFG_RCR after the BCR pass.
module cellram_pin_mux #(
    parameter logic [22:0] CFG_BCR      = 23'h089D1F,
`ifdef CELLRAM_RCR_WRITE_EN
    parameter logic [22:0] CFG_RCR      = 23'h000010,
`endif
    parameter int          PWRUP_CYCLES = 7500,
    parameter int          SETUP_CYCLES = 2,
    parameter int          WE_CYCLES    = 4,
    parameter int          HOLD_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    cellram_pin_mux_if.slave  sync_bus,
    input  logic              cfg_req,
    output logic              cfg_done,
    output logic [22:0]       cram_addr,
    output logic              cram_adv_n,
    output logic              cram_cre,
    output logic              cram_ce_n,
    output logic              cram_oe_n,
    output logic              cram_we_n,
    output logic              cram_lb_n,
    output logic              cram_ub_n,
    output logic              cram_clk_en,
    input  logic              cram_wait
);

    localparam int CW = $clog2(PWRUP_CYCLES + 1);

    // Reload values: a state lasts N cycles when loaded with N-1 and left at 0.
    localparam logic [CW-1:0] LOAD_PWRUP = CW'(PWRUP_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_SETUP = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_WE    = CW'(WE_CYCLES - 1);
    localparam logic [CW-1:0] LOAD_HOLD  = CW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_SETUP,
        ST_WRITE,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            pending_reg;
`ifdef CELLRAM_RCR_WRITE_EN
    logic            phase_reg;   // 0: BCR pass, 1: RCR pass
`endif

    // WAIT is only meaningful to the controller once it owns the pins.
    assign sync_bus.sync_wait = (state_reg == ST_RUN) ? cram_wait : 1'b0;

    // Configuration sequencer with registered pin outputs; pins are loaded
    // with the values of the state being entered on each transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_PWRUP;
            cnt_reg     <= LOAD_PWRUP;
            pending_reg <= 1'b0;
`ifdef CELLRAM_RCR_WRITE_EN
            phase_reg   <= 1'b0;
`endif
            cfg_done    <= 1'b0;
            cram_clk_en <= 1'b0;
            cram_addr   <= '0;
            cram_adv_n  <= 1'b1;
            cram_cre    <= 1'b0;
            cram_ce_n   <= 1'b1;
            cram_oe_n   <= 1'b1;
            cram_we_n   <= 1'b1;
            cram_lb_n   <= 1'b1;
            cram_ub_n   <= 1'b1;
        end else begin
            case (state_reg)
                ST_PWRUP: begin
                    if (cnt_reg == '0) begin
                        state_reg  <= ST_SETUP;
                        cnt_reg    <= LOAD_SETUP;
`ifdef CELLRAM_RCR_WRITE_EN
                        phase_reg  <= 1'b0;
`endif
                        cram_addr  <= CFG_BCR;
                        cram_ce_n  <= 1'b0;
                        cram_cre   <= 1'b1;
                        cram_adv_n <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                ST_SETUP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_WRITE;
                        cnt_reg   <= LOAD_WE;
                        cram_we_n <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                ST_WRITE: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_HOLD;
                        cnt_reg   <= LOAD_HOLD;
                        cram_we_n <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_reg == '0) begin
                        state_reg  <= ST_RELEASE;
                        cnt_reg    <= '0;
                        cram_ce_n  <= 1'b1;
                        cram_cre   <= 1'b0;
                        cram_adv_n <= 1'b1;
                        cram_addr  <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                ST_RELEASE: begin
`ifdef CELLRAM_RCR_WRITE_EN
                    if (!phase_reg) begin
                        // Second pass: same write shape, RCR value on the address.
                        state_reg  <= ST_SETUP;
                        cnt_reg    <= LOAD_SETUP;
                        phase_reg  <= 1'b1;
                        cram_addr  <= CFG_RCR;
                        cram_ce_n  <= 1'b0;
                        cram_cre   <= 1'b1;
                        cram_adv_n <= 1'b0;
                    end else begin
                        state_reg   <= ST_RUN;
                        cnt_reg     <= '0;
                        cfg_done    <= 1'b1;
                        cram_clk_en <= 1'b1;
                    end
`else
                    state_reg   <= ST_RUN;
                    cnt_reg     <= '0;
                    cfg_done    <= 1'b1;
                    cram_clk_en <= 1'b1;
`endif
                end
                ST_RUN: begin
                    cram_addr  <= sync_bus.sync_addr;
                    cram_adv_n <= sync_bus.sync_adv_n;
                    cram_cre   <= sync_bus.sync_cre;
                    cram_ce_n  <= sync_bus.sync_ce_n;
                    cram_oe_n  <= sync_bus.sync_oe_n;
                    cram_we_n  <= sync_bus.sync_we_n;
                    cram_lb_n  <= sync_bus.sync_lb_n;
                    cram_ub_n  <= sync_bus.sync_ub_n;
                    // Re-configure only while the controller has the device deselected;
                    // otherwise remember the request until it does.
                    if ((cfg_req || pending_reg) && sync_bus.sync_ce_n) begin
                        state_reg   <= ST_SETUP;
                        cnt_reg     <= LOAD_SETUP;
                        pending_reg <= 1'b0;
`ifdef CELLRAM_RCR_WRITE_EN
                        phase_reg   <= 1'b0;
`endif
                        cfg_done    <= 1'b0;
                        cram_clk_en <= 1'b0;
                        cram_addr   <= CFG_BCR;
                        cram_adv_n  <= 1'b0;
                        cram_cre    <= 1'b1;
                        cram_ce_n   <= 1'b0;
                        cram_oe_n   <= 1'b1;
                        cram_we_n   <= 1'b1;
                        cram_lb_n   <= 1'b1;
                        cram_ub_n   <= 1'b1;
                    end else if (cfg_req) begin
                        pending_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_PWRUP;
                    cnt_reg   <= LOAD_PWRUP;
                end
            endcase
        end
    end

endmodule

// File: doc/cellram_pin_mux.md
Name: cellram_pin_mux

Overview:
- Pin-level stage directly downstream of cellram_control_sync; consumes its pre-muxed sync_* bundle and drives the CellularRAM pins.
- After reset, waits out device power-up, then writes the Bus Configuration Register (BCR) with an asynchronous CRE write. Only then does it hand the pins to the synchronous controller.
- Supports a later re-configuration request while the sync side is idle.

Parameters:
- CFG_BCR, 23'h089D1F, value driven on cram_addr[23:1] during the BCR write; bits [19:18] of the value = 2'b10 select BCR.
- CFG_RCR, 23'h000010, RCR value; bits [19:18] = 2'b00. Used only with the optional feature.
- PWRUP_CYCLES, 7500, clk cycles held in PWRUP after reset (150 us at 50 MHz).
- SETUP_CYCLES, 2, cycles with address/CE/CRE stable before WE falls.
- WE_CYCLES, 4, cycles WE held low (meets tWP at 50 MHz).
- HOLD_CYCLES, 1, cycles after WE rises before CE/CRE release.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sync_addr  in  23  address from cellram_control_sync
- sync_adv_n, sync_cre, sync_ce_n, sync_oe_n, sync_we_n, sync_lb_n, sync_ub_n  in  1 each  controls from cellram_control_sync
- sync_wait  out  1  gated cram_wait returned to the sync controller (its o_wait)
- cfg_req  in  1  pulse requesting re-configuration
- cfg_done  out  1  high while pins are owned by the sync controller
- cram_addr  out  23  device address pins
- cram_adv_n, cram_cre, cram_ce_n, cram_oe_n, cram_we_n, cram_lb_n, cram_ub_n  out  1 each  device control pins
- cram_clk_en  out  1  enables the forwarded device clock
- cram_wait  in  1  device WAIT pin

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All cram_* outputs, cfg_done and cram_clk_en are registered.
- Reset values: cram_ce_n=1, cram_oe_n=1, cram_we_n=1, cram_adv_n=1, cram_lb_n=1, cram_ub_n=1, cram_cre=0, cram_addr=0, cram_clk_en=0, cfg_done=0, sync_wait=0. The state returns to PWRUP.
- Reset asserted mid-sequence aborts immediately to these values on the next edge.
- Single down-counter, width clog2(PWRUP_CYCLES+1), reloaded on each state entry. A state exits when the counter reaches 0, so each state lasts exactly its parameter in cycles.
- PWRUP: all pins idle (reset values). Exit to SETUP.
- SETUP: cram_ce_n=0, cram_cre=1, cram_adv_n=0, cram_addr=CFG_BCR, cram_oe_n=1, cram_we_n=1, byte enables high. Exit to WRITE.
- WRITE: same as SETUP with cram_we_n=0. Exit to HOLD.
- HOLD: cram_we_n=1; ce_n, cre, addr and adv_n unchanged. Exit to RELEASE.
- RELEASE: exactly 1 cycle. cram_ce_n=1, cram_cre=0, cram_adv_n=1, cram_addr=0. Exit to RUN.
- RUN:
  - cfg_done=1, cram_clk_en=1.
  - Each cram_X equals sync_X registered (1-cycle latency).
  - sync_wait = cram_wait, combinational.
  - Outside RUN, sync_wait=0.
- cfg_req:
  - Sampled only in RUN. Ignored (not queued) in every other state.
  - If cfg_req=1 and sync_ce_n=1 in the same cycle: next state is SETUP (PWRUP skipped), and cfg_done and cram_clk_en drop on that edge.
  - If sync_ce_n=0: request held pending, taken on the first cycle with sync_ce_n=1.
  - A pending request is cleared by rst.
- cfg_req=1 during any other state has no effect and does not extend any phase.
- dq is not handled here; cellram_control_sync owns dq. During configuration oe_n=1, so the device never drives it.

Optional Feature:
- Macro CELLRAM_RCR_WRITE_EN.
- Defined: after the BCR RELEASE, the block performs a second SETUP/WRITE/HOLD/RELEASE pass with cram_addr=CFG_RCR, then enters RUN.
  - A 1-bit phase flag selects the address.
  - cfg_req re-runs both writes.
- Undefined: a single BCR pass only. CFG_RCR is unused and the phase flag is not synthesised.

Test Plan:
- Reset, then run with PWRUP_CYCLES=10, SETUP=2, WE=4, HOLD=1 -> ce_n falls on cycle 10 after reset release. we_n is low for exactly cycles 12-15, cre=1 and addr=23'h089D1F throughout, ce_n rises on cycle 17, cfg_done=1 from cycle 18.
- In RUN, drive sync_addr=23'h123456, sync_we_n=0 -> cram_addr=23'h123456 and cram_we_n=0 one cycle later. cram_wait=1 -> sync_wait=1 in the same cycle.
- Pulse cfg_req while sync_ce_n=0 for 5 cycles -> no change until sync_ce_n=1. Then cfg_done=0 next edge, SETUP entered, and PWRUP is not repeated.
- Assert rst during WRITE -> next edge cram_we_n=1, ce_n=1, cre=0, and a full PWRUP is repeated.
- Pulse cfg_req during PWRUP -> ignored. Sequence timing is identical to the first scenario.
- With CELLRAM_RCR_WRITE_EN -> two WE-low pulses, addr 23'h089D1F then 23'h000010, a 1-cycle RELEASE between them, and cfg_done only after the second.
